// File: rtl/gc_defs.sv
// Shared definitions for the GameCube controller I2C front end:
// command bytes, neutral report, loader state encodings and read-map indices.
package gc_defs;

    localparam logic [7:0]  CMD_LOAD         = 8'h00;
    localparam logic [7:0]  CMD_NEUTRAL      = 8'h01;
    localparam logic [63:0] GC_NEUTRAL_STATE = 64'h0080_8080_8080_0000;
    localparam int          STATE_BYTES      = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LOAD    = 3'd2,
        S_NEUT    = 3'd3,
        S_DISCARD = 3'd4
    } loader_state_e;

    localparam logic [1:0] RD_IDX_STATUS = 2'd0;
    localparam logic [1:0] RD_IDX_POLL   = 2'd1;
    localparam logic [1:0] RD_IDX_STATE  = 2'd2;
    localparam logic [1:0] RD_IDX_LAST   = 2'd3;

endpackage

// File: rtl/gc_state_loader.sv
// Assembles I2C write payloads into a shadow report and commits it atomically on STOP;
// also serves a small read map (status, poll counter, first report byte).
//
// state     | meaning
// S_IDLE    | no transaction open; written bytes ignored
// S_CMD     | START seen, waiting for the command byte
// S_LOAD    | collecting report bytes into the shadow
// S_NEUT    | neutral command received, restore on STOP
// S_DISCARD | malformed transaction, flag error on STOP
module gc_state_loader
    import gc_defs::*;
#(
    parameter logic [63:0] NEUTRAL_STATE = GC_NEUTRAL_STATE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i2c_start,
    input  logic        i2c_stop,
    input  logic        i2c_wr_strobe,
    input  logic [7:0]  i2c_wr_data,
    input  logic        i2c_rd_strobe,
    output logic [7:0]  i2c_rd_data,
    input  logic        rumble,
    input  logic        poll_seen,
    output logic [63:0] controller_state,
    output logic        commit_err
);

    localparam logic [3:0] FULL_CNT = 4'(STATE_BYTES);

    loader_state_e state;
    logic [63:0]   shadow;
    logic [3:0]    byte_cnt;
    logic [7:0]    poll_cnt;
    logic [1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            shadow           <= '0;
            byte_cnt         <= '0;
            poll_cnt         <= '0;
            rd_ptr           <= '0;
            commit_err       <= 1'b0;
            controller_state <= NEUTRAL_STATE;
            i2c_rd_data      <= '0;
        end else begin
            if (poll_seen)
                poll_cnt <= poll_cnt + 8'd1;

            // Registered read mux reflects the pointer as of the previous edge.
            case (rd_ptr)
                RD_IDX_STATUS: i2c_rd_data <= {6'b0, commit_err, rumble};
                RD_IDX_POLL:   i2c_rd_data <= poll_cnt;
                RD_IDX_STATE:  i2c_rd_data <= controller_state[63:56];
                default:       i2c_rd_data <= 8'hFF;
            endcase

            if (i2c_rd_strobe && rd_ptr != RD_IDX_LAST)
                rd_ptr <= rd_ptr + 2'd1;

            // STOP is handled before a coincident START so a complete payload still commits.
            if (i2c_stop && state != S_IDLE) begin
                state <= S_IDLE;
                case (state)
                    S_LOAD: begin
                        if (byte_cnt == FULL_CNT) begin
                            controller_state <= shadow;
                            commit_err       <= 1'b0;
                        end else begin
                            commit_err <= 1'b1;
                        end
                    end
                    S_NEUT: begin
                        controller_state <= NEUTRAL_STATE;
                        commit_err       <= 1'b0;
                    end
                    S_DISCARD: commit_err <= 1'b1;
                    default: ;
                endcase
            end

            if (i2c_start) begin
                state    <= S_CMD;
                byte_cnt <= '0;
                shadow   <= '0;
                rd_ptr   <= '0;
            end else if (!i2c_stop && i2c_wr_strobe) begin
                case (state)
                    S_CMD: begin
                        if (i2c_wr_data == CMD_LOAD)
                            state <= S_LOAD;
                        else if (i2c_wr_data == CMD_NEUTRAL)
                            state <= S_NEUT;
                        else
                            state <= S_DISCARD;
                    end
                    S_LOAD: begin
                        if (byte_cnt == FULL_CNT) begin
                            state <= S_DISCARD;
                        end else begin
                            shadow   <= {shadow[55:0], i2c_wr_data};
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                    S_NEUT:  state <= S_DISCARD;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gc_state_loader.sv
// Directed bench for gc_state_loader: load/neutral commands, aborts, read map and poll counter.
module tb_gc_state_loader;

    localparam logic [63:0] NEUTRAL = 64'h0080_8080_8080_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        i2c_start, i2c_stop, i2c_wr_strobe, i2c_rd_strobe;
    logic [7:0]  i2c_wr_data;
    logic [7:0]  i2c_rd_data;
    logic        rumble, poll_seen;
    logic [63:0] controller_state;
    logic        commit_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] latched;

    always #5 clk = ~clk;

    // Stand-in for gc_controller latching the report on a poll.
    always @(posedge clk) if (poll_seen) latched <= controller_state;

    gc_state_loader dut (
        .clk              (clk),
        .reset            (reset),
        .i2c_start        (i2c_start),
        .i2c_stop         (i2c_stop),
        .i2c_wr_strobe    (i2c_wr_strobe),
        .i2c_wr_data      (i2c_wr_data),
        .i2c_rd_strobe    (i2c_rd_strobe),
        .i2c_rd_data      (i2c_rd_data),
        .rumble           (rumble),
        .poll_seen        (poll_seen),
        .controller_state (controller_state),
        .commit_err       (commit_err)
    );

    task automatic do_start();
        @(negedge clk) i2c_start = 1'b1;
        @(negedge clk) i2c_start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk) i2c_stop = 1'b1;
        @(negedge clk) i2c_stop = 1'b0;
    endtask

    task automatic do_byte(input logic [7:0] d);
        @(negedge clk) begin i2c_wr_strobe = 1'b1; i2c_wr_data = d; end
        @(negedge clk) i2c_wr_strobe = 1'b0;
    endtask

    task automatic do_rd();
        @(negedge clk) i2c_rd_strobe = 1'b1;
        @(negedge clk) i2c_rd_strobe = 1'b0;
    endtask

    task automatic do_poll();
        @(negedge clk) poll_seen = 1'b1;
        @(negedge clk) poll_seen = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic load_payload(input logic [63:0] p);
        do_start();
        do_byte(8'h00);
        for (int i = 7; i >= 0; i--) do_byte(p[i*8 +: 8]);
    endtask

    // Read status byte right after START: data valid one clock later.
    task automatic read_status(output logic [7:0] v);
        do_start();
        @(negedge clk) v = i2c_rd_data;
        do_stop();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (controller_state !== NEUTRAL) begin
            n_bad++; $display("FAIL reset_state got=%h exp=%h", controller_state, NEUTRAL);
        end
        n_cmp++;
        if (commit_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_err got=%b exp=0", commit_err);
        end
    endtask

    task automatic test_load();
        load_payload(64'h1122334455667788);
        n_cmp++;
        if (controller_state !== NEUTRAL) begin
            n_bad++; $display("FAIL load_before_stop got=%h exp=%h", controller_state, NEUTRAL);
        end
        do_stop();
        n_cmp++;
        if (controller_state !== 64'h1122334455667788) begin
            n_bad++; $display("FAIL load_commit got=%h exp=1122334455667788", controller_state);
        end
        n_cmp++;
        if (commit_err !== 1'b0) begin
            n_bad++; $display("FAIL load_err got=%b exp=0", commit_err);
        end
    endtask

    task automatic test_short_then_neutral();
        logic [7:0] v;
        do_start();
        do_byte(8'h00);
        for (int i = 0; i < 7; i++) do_byte(8'h50 + 8'(i));
        do_stop();
        n_cmp++;
        if (controller_state !== 64'h1122334455667788) begin
            n_bad++; $display("FAIL short_unchanged got=%h exp=1122334455667788", controller_state);
        end
        n_cmp++;
        if (commit_err !== 1'b1) begin
            n_bad++; $display("FAIL short_err got=%b exp=1", commit_err);
        end
        read_status(v);
        n_cmp++;
        if (v !== 8'h02) begin
            n_bad++; $display("FAIL status_err_bit got=%h exp=02", v);
        end
        do_start();
        do_byte(8'h01);
        do_stop();
        n_cmp++;
        if (controller_state !== NEUTRAL) begin
            n_bad++; $display("FAIL neutral_cmd got=%h exp=%h", controller_state, NEUTRAL);
        end
        n_cmp++;
        if (commit_err !== 1'b0) begin
            n_bad++; $display("FAIL neutral_err got=%b exp=0", commit_err);
        end
    endtask

    task automatic test_repeated_start();
        do_start();
        do_byte(8'h00);
        for (int i = 0; i < 4; i++) do_byte(8'h11 * 8'(i + 1));
        load_payload(64'hAABBCCDDEEFF0102);
        do_stop();
        n_cmp++;
        if (controller_state !== 64'hAABBCCDDEEFF0102) begin
            n_bad++; $display("FAIL rstart_commit got=%h exp=AABBCCDDEEFF0102", controller_state);
        end
        n_cmp++;
        if (commit_err !== 1'b0) begin
            n_bad++; $display("FAIL rstart_err got=%b exp=0", commit_err);
        end
    endtask

    task automatic test_malformed();
        // Ninth payload byte discards the transaction.
        load_payload(64'h0102030405060708);
        do_byte(8'h09);
        do_stop();
        n_cmp++;
        if (controller_state !== 64'hAABBCCDDEEFF0102 || commit_err !== 1'b1) begin
            n_bad++; $display("FAIL ninth_byte got=%h/%b exp=AABBCCDDEEFF0102/1", controller_state, commit_err);
        end
        // Unknown command.
        do_start();
        do_byte(8'h7E);
        do_stop();
        n_cmp++;
        if (controller_state !== 64'hAABBCCDDEEFF0102 || commit_err !== 1'b1) begin
            n_bad++; $display("FAIL bad_cmd got=%h/%b exp=AABBCCDDEEFF0102/1", controller_state, commit_err);
        end
        // Data after the neutral command.
        do_start();
        do_byte(8'h01);
        do_byte(8'h33);
        do_stop();
        n_cmp++;
        if (controller_state !== 64'hAABBCCDDEEFF0102 || commit_err !== 1'b1) begin
            n_bad++; $display("FAIL neut_extra got=%h/%b exp=AABBCCDDEEFF0102/1", controller_state, commit_err);
        end
        // Read-only transaction leaves the error flag alone.
        do_start();
        do_stop();
        n_cmp++;
        if (commit_err !== 1'b1) begin
            n_bad++; $display("FAIL readonly_err got=%b exp=1", commit_err);
        end
        // Writes without START are ignored.
        do_byte(8'h00);
        for (int i = 0; i < 8; i++) do_byte(8'h44);
        do_stop();
        n_cmp++;
        if (controller_state !== 64'hAABBCCDDEEFF0102 || commit_err !== 1'b1) begin
            n_bad++; $display("FAIL idle_write got=%h/%b exp=AABBCCDDEEFF0102/1", controller_state, commit_err);
        end
    endtask

    task automatic test_stop_start_same_cycle();
        load_payload(64'hCAFEF00D12345678);
        @(negedge clk) begin i2c_stop = 1'b1; i2c_start = 1'b1; end
        @(negedge clk) begin i2c_stop = 1'b0; i2c_start = 1'b0; end
        n_cmp++;
        if (controller_state !== 64'hCAFEF00D12345678 || commit_err !== 1'b0) begin
            n_bad++; $display("FAIL stop_start_commit got=%h/%b exp=CAFEF00D12345678/0", controller_state, commit_err);
        end
        // The START opened a new transaction: a neutral command now applies.
        do_byte(8'h01);
        do_stop();
        n_cmp++;
        if (controller_state !== NEUTRAL) begin
            n_bad++; $display("FAIL stop_start_cmd got=%h exp=%h", controller_state, NEUTRAL);
        end
    endtask

    task automatic test_poll_atomic();
        load_payload(64'h1122334455667788);
        @(negedge clk) begin i2c_stop = 1'b1; poll_seen = 1'b1; end
        @(negedge clk) begin i2c_stop = 1'b0; poll_seen = 1'b0; end
        n_cmp++;
        if (latched !== NEUTRAL) begin
            n_bad++; $display("FAIL poll_on_commit got=%h exp=%h", latched, NEUTRAL);
        end
        do_poll();
        n_cmp++;
        if (latched !== 64'h1122334455667788) begin
            n_bad++; $display("FAIL poll_after got=%h exp=1122334455667788", latched);
        end
    endtask

    task automatic test_poll_wrap_and_read();
        logic [7:0] exp_rd [4];
        exp_rd[0] = 8'h01; exp_rd[1] = 8'h00; exp_rd[2] = 8'h00; exp_rd[3] = 8'hFF;
        do_reset();
        rumble = 1'b1;
        for (int i = 0; i < 3; i++) do_poll();
        do_start();
        do_rd();
        @(negedge clk);
        n_cmp++;
        if (i2c_rd_data !== 8'h03) begin
            n_bad++; $display("FAIL poll_cnt3 got=%h exp=03", i2c_rd_data);
        end
        do_stop();
        for (int i = 0; i < 253; i++) do_poll();
        do_start();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i2c_rd_data !== exp_rd[i]) begin
                n_bad++; $display("FAIL read_map[%0d] got=%h exp=%h", i, i2c_rd_data, exp_rd[i]);
            end
            do_rd();
            @(negedge clk);
        end
        n_cmp++;
        if (i2c_rd_data !== 8'hFF) begin
            n_bad++; $display("FAIL read_sat got=%h exp=FF", i2c_rd_data);
        end
        do_stop();
        rumble = 1'b0;
    endtask

    task automatic test_reset_mid();
        load_payload(64'h0F0E0D0C0B0A0908);
        do_stop();
        n_cmp++;
        if (controller_state !== 64'h0F0E0D0C0B0A0908) begin
            n_bad++; $display("FAIL pre_reset_commit got=%h exp=0F0E0D0C0B0A0908", controller_state);
        end
        do_start();
        do_byte(8'h00);
        for (int i = 0; i < 5; i++) do_byte(8'h21 + 8'(i));
        do_reset();
        do_stop();
        n_cmp++;
        if (controller_state !== NEUTRAL) begin
            n_bad++; $display("FAIL reset_mid_state got=%h exp=%h", controller_state, NEUTRAL);
        end
        n_cmp++;
        if (commit_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_err got=%b exp=0", commit_err);
        end
    endtask

    initial begin
        reset = 1'b1;
        i2c_start = 1'b0; i2c_stop = 1'b0; i2c_wr_strobe = 1'b0;
        i2c_rd_strobe = 1'b0; i2c_wr_data = 8'h00;
        rumble = 1'b0; poll_seen = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_load();
        test_short_then_neutral();
        test_repeated_start();
        test_malformed();
        test_stop_start_same_cycle();
        test_poll_atomic();
        test_poll_wrap_and_read();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
